// File: rtl/pixie_video_out.sv
// Pixie video-output stage: line-locked pixel strobe, two-stage pixel pipeline,
// per-frame palette latch, frame counter. Optional scanline dimming via PIXIE_SCANLINE_EN.
module pixie_video_out #(
  parameter int CE_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       video,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [1:0] palette,
  input  logic       scanline,
  output logic       ce_pix,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hblank_out,
  output logic       vblank_out,
  output logic       de,
  output logic [7:0] frame_cnt
);

  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);

  logic [3:0]  div_q, div_d;
  logic        run_q;
  logic        hsync_d_q, vsync_d_q;
  logic [1:0]  pal_q, pal_d;
  logic        odd_line_q, odd_line_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        s1_video_q, s1_hs_q, s1_vs_q, s1_hb_q, s1_vb_q;
  logic        s1_video_d, s1_hs_d, s1_vs_d, s1_hb_d, s1_vb_d;
  logic [23:0] rgb_q, rgb_d, pix;
  logic        hs_q, vs_q, hb_q, vb_q, de_q;
  logic        hs_d, vs_d, hb_d, vb_d, de_d;
  logic        hs_rise, vs_rise, ce;

  function automatic logic [23:0] fg_colour(input logic [1:0] p);
    case (p)
      2'd0:    fg_colour = 24'hFFFFFF;
      2'd1:    fg_colour = 24'h33FF33;
      2'd2:    fg_colour = 24'hFFB000;
      default: fg_colour = 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] bg_colour(input logic [1:0] p);
    bg_colour = (p == 2'd3) ? 24'hFFFFFF : 24'h000000;
  endfunction

  assign hs_rise = hsync & ~hsync_d_q;
  assign vs_rise = vsync & ~vsync_d_q;
  // run_q keeps the strobe low through reset when CE_DIV=1 (div is always 0 then)
  assign ce      = run_q && (div_q == DIV_LAST);

`ifdef PIXIE_SCANLINE_EN
  logic s1_odd_q, s1_scan_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_odd_q  <= 1'b0;
      s1_scan_q <= 1'b0;
    end else if (ce) begin
      s1_odd_q  <= odd_line_q;
      s1_scan_q <= scanline;
    end
  end
`else
  logic unused_scanline;
  assign unused_scanline = scanline ^ odd_line_q;
`endif

  always_comb begin
    div_d       = (hs_rise || div_q == DIV_LAST) ? 4'd0 : 4'(div_q + 4'd1);
    pal_d       = vs_rise ? palette : pal_q;
    frame_cnt_d = vs_rise ? 8'(frame_cnt_q + 8'd1) : frame_cnt_q;
    // A vsync edge clears parity even if an hsync edge lands in the same cycle
    odd_line_d  = vs_rise ? 1'b0 : (hs_rise ? ~odd_line_q : odd_line_q);

    s1_video_d = s1_video_q;
    s1_hs_d    = s1_hs_q;
    s1_vs_d    = s1_vs_q;
    s1_hb_d    = s1_hb_q;
    s1_vb_d    = s1_vb_q;
    rgb_d      = rgb_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    hb_d       = hb_q;
    vb_d       = vb_q;
    de_d       = de_q;

    pix = s1_video_q ? fg_colour(pal_q) : bg_colour(pal_q);
`ifdef PIXIE_SCANLINE_EN
    if (s1_scan_q && s1_odd_q)
      pix = {1'b0, pix[23:17], 1'b0, pix[15:9], 1'b0, pix[7:1]};
`endif
    if (s1_hb_q || s1_vb_q)
      pix = 24'h000000;

    if (ce) begin
      s1_video_d = video;
      s1_hs_d    = hsync;
      s1_vs_d    = vsync;
      s1_hb_d    = hblank;
      s1_vb_d    = vblank;
      rgb_d      = pix;
      hs_d       = s1_hs_q;
      vs_d       = s1_vs_q;
      hb_d       = s1_hb_q;
      vb_d       = s1_vb_q;
      de_d       = ~(s1_hb_q | s1_vb_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= 4'd0;
      run_q       <= 1'b0;
      hsync_d_q   <= 1'b0;
      vsync_d_q   <= 1'b0;
      pal_q       <= 2'd0;
      odd_line_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
      s1_video_q  <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_hb_q     <= 1'b0;
      s1_vb_q     <= 1'b0;
      rgb_q       <= 24'h000000;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      hb_q        <= 1'b0;
      vb_q        <= 1'b0;
      de_q        <= 1'b0;
    end else begin
      div_q       <= div_d;
      run_q       <= 1'b1;
      hsync_d_q   <= hsync;
      vsync_d_q   <= vsync;
      pal_q       <= pal_d;
      odd_line_q  <= odd_line_d;
      frame_cnt_q <= frame_cnt_d;
      s1_video_q  <= s1_video_d;
      s1_hs_q     <= s1_hs_d;
      s1_vs_q     <= s1_vs_d;
      s1_hb_q     <= s1_hb_d;
      s1_vb_q     <= s1_vb_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
      de_q        <= de_d;
    end
  end

  assign ce_pix     = ce;
  assign r          = rgb_q[23:16];
  assign g          = rgb_q[15:8];
  assign b          = rgb_q[7:0];
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign hblank_out = hb_q;
  assign vblank_out = vb_q;
  assign de         = de_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixie_video_out.sv
// Directed bench for pixie_video_out: divider/reset, line lock (CE_DIV=3 copy),
// palette latch, latency, blanking, syncs, scanline and frame counter wrap.
module tb_pixie_video_out;

  logic       clk = 1'b0;
  logic       reset_n, video, hsync, vsync, hblank, vblank, scanline;
  logic [1:0] palette;
  logic       ce_pix, hs_out, vs_out, hblank_out, vblank_out, de;
  logic [7:0] r, g, b, frame_cnt;
  logic       ce_pix3, hs_out3, vs_out3, hblank_out3, vblank_out3, de3;
  logic [7:0] r3, g3, b3, frame_cnt3;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] exp_frames = 8'd0;
  logic [23:0] exp_dim;

  always #5 clk = ~clk;

  pixie_video_out #(.CE_DIV(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .video(video), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .palette(palette), .scanline(scanline),
    .ce_pix(ce_pix), .r(r), .g(g), .b(b), .hs_out(hs_out), .vs_out(vs_out),
    .hblank_out(hblank_out), .vblank_out(vblank_out), .de(de), .frame_cnt(frame_cnt)
  );

  pixie_video_out #(.CE_DIV(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .video(video), .hsync(hsync), .vsync(vsync),
    .hblank(hblank), .vblank(vblank), .palette(palette), .scanline(scanline),
    .ce_pix(ce_pix3), .r(r3), .g(g3), .b(b3), .hs_out(hs_out3), .vs_out(vs_out3),
    .hblank_out(hblank_out3), .vblank_out(vblank_out3), .de(de3), .frame_cnt(frame_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance through the next ce_pix edge of the CE_DIV=2 instance.
  task automatic strobe();
    int n;
    n = 0;
    while (!ce_pix && n < 20) begin
      tick();
      n++;
    end
    if (!ce_pix) check("ce_timeout", {31'd0, ce_pix}, 32'd1);
    tick();
  endtask

  task automatic pixel();
    strobe();
    strobe();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    exp_frames = exp_frames + 8'd1;
    tick();
  endtask

  initial begin
`ifdef PIXIE_SCANLINE_EN
    exp_dim = 24'h7F7F7F;
`else
    exp_dim = 24'hFFFFFF;
`endif
    reset_n = 1'b0; video = 1'b0; hsync = 1'b0; vsync = 1'b0;
    hblank = 1'b0; vblank = 1'b0; scanline = 1'b0; palette = 2'd0;

    // Reset and free-running divider
    repeat (3) tick();
    check("rst_ce", {31'd0, ce_pix}, 32'd0);
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_sync", {27'd0, hs_out, vs_out, hblank_out, vblank_out, de}, 32'd0);
    check("rst_frame", {24'd0, frame_cnt}, 32'd0);
    reset_n = 1'b1;
    tick(); check("div_c1", {30'd0, ce_pix, ce_pix3}, 32'b10);
    tick(); check("div_c2", {30'd0, ce_pix, ce_pix3}, 32'b01);
    tick(); check("div_c3", {30'd0, ce_pix, ce_pix3}, 32'b10);
    tick(); check("div_c4", {30'd0, ce_pix, ce_pix3}, 32'b00);

    // Line lock on CE_DIV=3: div is 1 here; hsync edge reloads it to 0
    hsync = 1'b1;
    tick(); check("lock_c1", {31'd0, ce_pix3}, 32'd0);
    tick(); check("lock_c2", {31'd0, ce_pix3}, 32'd0);
    tick(); check("lock_c3", {31'd0, ce_pix3}, 32'd1);
    hsync = 1'b0;

    // Palette latch on vsync edge only
    palette = 2'd1; video = 1'b1;
    vs_pulse();
    pixel();
    check("pal_green", {8'd0, r, g, b}, 32'h33FF33);
    check("pal_de", {31'd0, de}, 32'd1);
    palette = 2'd2;
    pixel();
    check("pal_hold", {8'd0, r, g, b}, 32'h33FF33);
    vs_pulse();
    pixel();
    check("pal_amber", {8'd0, r, g, b}, 32'hFFB000);
    check("frame_pal", {24'd0, frame_cnt}, {24'd0, exp_frames});

    // Two-strobe latency
    video = 1'b0;
    strobe();
    check("lat_s1", {8'd0, r, g, b}, 32'hFFB000);
    strobe();
    check("lat_s2", {8'd0, r, g, b}, 32'h000000);

    // Blanking with inverse palette
    palette = 2'd3;
    vs_pulse();
    video = 1'b1; hblank = 1'b1;
    pixel();
    check("blank_rgb", {8'd0, r, g, b}, 32'h000000);
    check("blank_flags", {30'd0, hblank_out, de}, 32'b10);
    hblank = 1'b0;
    pixel();
    check("inv_fg", {8'd0, r, g, b}, 32'h000000);
    check("inv_de", {30'd0, hblank_out, de}, 32'b01);
    video = 1'b0;
    pixel();
    check("inv_bg", {8'd0, r, g, b}, 32'hFFFFFF);

    // Sync and vblank alignment
    hsync = 1'b1;
    pixel();
    check("hs_out", {31'd0, hs_out}, 32'd1);
    hsync = 1'b0; vblank = 1'b1;
    pixel();
    check("vblank_flags", {29'd0, hs_out, vblank_out, de}, 32'b010);
    check("vblank_rgb", {8'd0, r, g, b}, 32'h000000);
    vblank = 1'b0;

    // Scanline: line 0 full intensity, odd line dimmed when enabled
    palette = 2'd0; scanline = 1'b1; video = 1'b1;
    vs_pulse();
    pixel();
    check("scan_even", {8'd0, r, g, b}, 32'hFFFFFF);
    hsync = 1'b1; tick();
    hsync = 1'b0; tick();
    pixel();
    check("scan_odd", {8'd0, r, g, b}, {8'd0, exp_dim});
    scanline = 1'b0;

    // Frame counter through 255 and wrap
    for (int i = 0; i < 256; i++) begin
      vs_pulse();
      if (exp_frames[4:0] == 5'd0 || exp_frames == 8'hFF)
        check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_frames});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
